// File: rtl/apresentador_sequencia_if.sv
// Play-interface bundle between the sequence presenter and the game controller.
// The slave side is the presenter; the master side drives commands and the read address.
interface apresentador_sequencia_if;
    logic       inicia_jogo;
    logic       mostra;
    logic [2:0] rodada;
    logic       dificuldade;
    logic [2:0] endereco_leitura;
    logic [7:0] dado_leitura;
    logic [7:0] leds;
    logic       ocupado;
    logic       fim_apresentacao;

    modport master (
        output inicia_jogo, mostra, rodada, dificuldade, endereco_leitura,
        input  dado_leitura, leds, ocupado, fim_apresentacao
    );

    modport slave (
        input  inicia_jogo, mostra, rodada, dificuldade, endereco_leitura,
        output dado_leitura, leds, ocupado, fim_apresentacao
    );
endinterface

// File: rtl/apresentador_sequencia.sv
// Sequence presenter: fills an 8-entry one-hot memory from a free-running LFSR,
// replays entries 0..rodada on the LEDs with difficulty-dependent timing, and
// offers a registered read port to the play checker.
module apresentador_sequencia #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          T_ON_0  = 1000,
    parameter int          T_OFF_0 = 500,
    parameter int          T_ON_1  = 500,
    parameter int          T_OFF_1 = 250,
    parameter int          W_T     = 13
) (
    input  logic                     clock,
    input  logic                     reset,
    apresentador_sequencia_if.slave  bus
);

    localparam int T_MAX = (2 ** W_T) - 1;

    // Reject parameter sets the timers or the LFSR cannot honour.
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("apresentador_sequencia: SEED must be nonzero");
    end
    if (T_ON_0 < 1 || T_ON_0 > T_MAX || T_OFF_0 < 1 || T_OFF_0 > T_MAX ||
        T_ON_1 < 1 || T_ON_1 > T_MAX || T_OFF_1 < 1 || T_OFF_1 > T_MAX) begin : g_bad_timing
        $error("apresentador_sequencia: every T_* must be in 1..2**W_T-1");
    end

    // Terminal counts are stored minus one so the timer compares against its last value.
    localparam logic [W_T-1:0] TON0_M1  = W_T'(T_ON_0 - 1);
    localparam logic [W_T-1:0] TOFF0_M1 = W_T'(T_OFF_0 - 1);
    localparam logic [W_T-1:0] TON1_M1  = W_T'(T_ON_1 - 1);
    localparam logic [W_T-1:0] TOFF1_M1 = W_T'(T_OFF_1 - 1);

    typedef enum logic [2:0] {OCIOSO, GERA, ACENDE, APAGA, FIM} estado_t;

    estado_t          estado, estado_nxt;
    logic [15:0]      lfsr;
    logic [7:0][7:0]  mem;
    logic [2:0]       idx, idx_nxt;
    logic [2:0]       k, k_nxt;
    logic [2:0]       n, n_nxt;
    logic             dif, dif_nxt;
    logic [W_T-1:0]   timer, timer_nxt;
    logic             grava;
    logic [7:0]       leds_q, leds_nxt;
    logic [7:0]       dado_q;
    logic [W_T-1:0]   t_on_m1, t_off_m1;
    logic             fb;

    assign fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign t_on_m1  = dif ? TON1_M1  : TON0_M1;
    assign t_off_m1 = dif ? TOFF1_M1 : TOFF0_M1;

    // Next-state, counters and LED value for the coming cycle.
    always_comb begin
        estado_nxt = estado;
        idx_nxt    = idx;
        k_nxt      = k;
        n_nxt      = n;
        dif_nxt    = dif;
        timer_nxt  = timer;
        grava      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.inicia_jogo) begin
                    estado_nxt = GERA;
                    k_nxt      = 3'd0;
                end else if (bus.mostra) begin
                    estado_nxt = ACENDE;
                    idx_nxt    = 3'd0;
                    n_nxt      = bus.rodada;
                    dif_nxt    = bus.dificuldade;
                    timer_nxt  = '0;
                end
            end
            GERA: begin
                grava = 1'b1;
                k_nxt = k + 3'd1;
                if (k == 3'd7) estado_nxt = OCIOSO;
            end
            ACENDE: begin
                if (timer == t_on_m1) begin
                    estado_nxt = APAGA;
                    timer_nxt  = '0;
                end else begin
                    timer_nxt = timer + W_T'(1);
                end
            end
            APAGA: begin
                if (timer == t_off_m1) begin
                    timer_nxt = '0;
                    if (idx == n) begin
                        estado_nxt = FIM;
                    end else begin
                        idx_nxt    = idx + 3'd1;
                        estado_nxt = ACENDE;
                    end
                end else begin
                    timer_nxt = timer + W_T'(1);
                end
            end
            FIM:     estado_nxt = OCIOSO;
            default: estado_nxt = OCIOSO;
        endcase
        // LEDs are registered from the next state so they switch exactly at transitions.
        leds_nxt = (estado_nxt == ACENDE) ? mem[idx_nxt] : 8'h00;
    end

    // State, LFSR and replay bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            lfsr   <= SEED;
            idx    <= 3'd0;
            k      <= 3'd0;
            n      <= 3'd0;
            dif    <= 1'b0;
            timer  <= '0;
            leds_q <= 8'h00;
        end else begin
            estado <= estado_nxt;
            lfsr   <= {lfsr[14:0], fb};
            idx    <= idx_nxt;
            k      <= k_nxt;
            n      <= n_nxt;
            dif    <= dif_nxt;
            timer  <= timer_nxt;
            leds_q <= leds_nxt;
        end
    end

    // Sequence memory write and registered read; a colliding read sees the old entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem    <= '0;
            dado_q <= 8'h00;
        end else begin
            if (grava) mem[k] <= 8'b1 << lfsr[2:0];
            dado_q <= mem[bus.endereco_leitura];
        end
    end

    assign bus.leds             = leds_q;
    assign bus.dado_leitura     = dado_q;
    assign bus.ocupado          = (estado != OCIOSO);
    assign bus.fim_apresentacao = (estado == FIM);

endmodule

// File: tb/tb_apresentador_sequencia.sv
// Self-checking bench for apresentador_sequencia: directed scenarios with
// randomized gaps, rounds and difficulties, checked against an LFSR model and
// an expected-LED timeline built from the replay rules.
module tb_apresentador_sequencia;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clock;
    logic reset;
    apresentador_sequencia_if bus ();

    apresentador_sequencia #(
        .SEED(SEED), .T_ON_0(4), .T_OFF_0(2), .T_ON_1(2), .T_OFF_1(1), .W_T(13)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_lfsr;
    logic [7:0]  exp_mem [8];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR: free-runs alongside the DUT, reloaded by reset.
    always @(posedge clock) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a new game (optionally with a simultaneous mostra), check the 8 GERA
    // cycles, then read the whole memory back.
    task automatic gera(input bit with_mostra);
        bus.inicia_jogo = 1'b1;
        bus.mostra      = with_mostra;
        bus.rodada      = 3'($urandom_range(0, 7));
        @(negedge clock);
        bus.inicia_jogo = 1'b0;
        bus.mostra      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_mem[i] = 8'b1 << m_lfsr[2:0];
            chk("gera_ocupado", {7'b0, bus.ocupado}, 8'd1);
            chk("gera_leds", bus.leds, 8'h00);
            @(negedge clock);
        end
        chk("gera_done_ocupado", {7'b0, bus.ocupado}, 8'd0);
        for (int a = 0; a < 8; a++) begin
            bus.endereco_leitura = 3'(a);
            @(negedge clock);
            chk("mem_read", bus.dado_leitura, exp_mem[a]);
            chk("mem_onehot", {7'b0, $onehot(bus.dado_leitura)}, 8'd1);
            chk("idle_leds", bus.leds, 8'h00);
        end
    endtask

    // Request a replay and check every cycle against the expected timeline.
    task automatic replay(input logic [2:0] n, input logic d, input bit inject);
        int         ton, toff, len;
        logic [7:0] q[$];
        ton  = d ? 2 : 4;
        toff = d ? 1 : 2;
        for (int i = 0; i <= int'(n); i++) begin
            repeat (ton)  q.push_back(exp_mem[i]);
            repeat (toff) q.push_back(8'h00);
        end
        q.push_back(8'h00);
        len = q.size();
        bus.mostra      = 1'b1;
        bus.rodada      = n;
        bus.dificuldade = d;
        @(negedge clock);
        bus.mostra = 1'b0;
        for (int c = 1; c <= len; c++) begin
            if (inject && c == 2) begin
                bus.mostra      = 1'b1;
                bus.inicia_jogo = 1'b1;
                bus.rodada      = ~n;
                bus.dificuldade = ~d;
            end else if (inject && c == 3) begin
                bus.mostra      = 1'b0;
                bus.inicia_jogo = 1'b0;
            end
            chk("replay_leds", bus.leds, q[c-1]);
            chk("replay_fim", {7'b0, bus.fim_apresentacao}, (c == len) ? 8'd1 : 8'd0);
            chk("replay_ocupado", {7'b0, bus.ocupado}, 8'd1);
            @(negedge clock);
        end
        chk("after_ocupado", {7'b0, bus.ocupado}, 8'd0);
        chk("after_fim", {7'b0, bus.fim_apresentacao}, 8'd0);
        chk("after_leds", bus.leds, 8'h00);
    endtask

    initial begin
        reset                = 1'b1;
        bus.inicia_jogo      = 1'b0;
        bus.mostra           = 1'b0;
        bus.rodada           = 3'd0;
        bus.dificuldade      = 1'b0;
        bus.endereco_leitura = 3'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state.
        chk("rst_leds", bus.leds, 8'h00);
        chk("rst_dado", bus.dado_leitura, 8'h00);
        chk("rst_ocupado", {7'b0, bus.ocupado}, 8'd0);
        chk("rst_fim", {7'b0, bus.fim_apresentacao}, 8'd0);

        // New game, then the two directed replays.
        repeat ($urandom_range(0, 5)) @(negedge clock);
        gera(1'b0);
        replay(3'd2, 1'b0, 1'b0);
        replay(3'd7, 1'b1, 1'b0);

        // Simultaneous inicia_jogo and mostra: only the sequence is generated.
        gera(1'b1);
        chk("no_replay_ocupado", {7'b0, bus.ocupado}, 8'd0);
        replay(3'd3, 1'b0, 1'b0);

        // Commands and input changes during a replay have no effect.
        replay(3'd4, 1'b0, 1'b1);
        replay(3'd1, 1'b1, 1'b1);

        // Randomized games and replays.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 7)) @(negedge clock);
            gera(1'b0);
            replay(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the third GERA cycle discards the whole sequence.
        bus.inicia_jogo = 1'b1;
        @(negedge clock);
        bus.inicia_jogo = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("gera_rst_ocupado", {7'b0, bus.ocupado}, 8'd0);
        for (int a = 0; a < 8; a++) begin
            bus.endereco_leitura = 3'(a);
            @(negedge clock);
            chk("cleared_mem", bus.dado_leitura, 8'h00);
        end

        // Reset during a replay blanks the LEDs and suppresses fim.
        gera(1'b0);
        bus.mostra      = 1'b1;
        bus.rodada      = 3'd5;
        bus.dificuldade = 1'b0;
        @(negedge clock);
        bus.mostra = 1'b0;
        chk("pre_rst_leds", bus.leds, exp_mem[0]);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("replay_rst_leds", bus.leds, 8'h00);
        chk("replay_rst_ocupado", {7'b0, bus.ocupado}, 8'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            chk("no_fim_after_rst", {7'b0, bus.fim_apresentacao}, 8'd0);
            chk("dark_after_rst", bus.leds, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
